writeback_queue: RTL and testbench
==================================

Name: writeback_queue

Overview:
- Writeback stage directly upstream of the 32-entry register file.
- Accepts results from the memory unit and the ALU and queues them in order.
- Drains one write per cycle onto the register file's write port (RDadd, RD, enableLoad).
- Provides a forwarding lookup so decode can read results that are queued or in flight but not yet written.

Parameters:
DEPTH, 4, queue entries (power of two, >= 2)
AW, 2, log2(DEPTH); pointer width

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
resetIn  input  1  synchronous, active-high reset
mem_valid  input  1  memory result valid
mem_dest  input  5  memory result destination register
mem_data  input  32  memory result value
mem_ready  output  1  memory result accepted when mem_valid & mem_ready
alu_valid  input  1  ALU result valid
alu_dest  input  5  ALU result destination register
alu_data  input  32  ALU result value
alu_ready  output  1  ALU result accepted when alu_valid & alu_ready
RDadd  output  5  register file write address
RD  output  32  register file write data
enableLoad  output  1  register file write enable
rs_addr  input  5  forwarding lookup address
rs_hit  output  1  newer value for rs_addr pending (combinational)
rs_data  output  32  youngest pending value for rs_addr (combinational)
wb_idle  output  1  queue empty and enableLoad low

Behaviour:
- Reset: when resetIn=1 at an edge, the following are cleared:
  - count, rd_ptr and wr_ptr cleared to 0
  - RDadd=0, RD=0, enableLoad=0
  - all entry valid bits cleared
- While resetIn=1:
  - mem_ready=alu_ready=0 and no pushes occur.
  - Reset mid-drain discards all queued entries without writing them.
- Free slots: free = DEPTH - count. count is the registered value at the start of the cycle; a same-cycle pop does not add a slot.
- mem_ready = (free >= 1).
- alu_ready = (free >= 2) if mem_valid, else (free >= 1). alu_ready must not depend on mem_ready.
- Order on simultaneous acceptance: the mem entry is written first, then the alu entry (the memory op is the older instruction). wr_ptr advances by 2.
- Register 0 drop: an accepted transfer with dest=0 is consumed (ready honoured) but not enqueued. It consumes no slot and produces no write.
- Drain: at each edge with count>0:
  - Head entry loads RDadd/RD, enableLoad<=1, rd_ptr increments, count decrements.
  - At an edge with count=0: enableLoad<=0, RDadd/RD hold their previous values.
- Latency: a result accepted at edge E into an empty queue drives enableLoad=1 from edge E+1 to E+2. The register file captures it at E+2.
- Throughput: one write per cycle sustained. Push and pop at the same edge are both performed; count changes by pushes minus pop.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH; no overflow is possible under the ready rules.
- Forwarding search covers the output stage (when enableLoad=1) plus all valid queue entries.
  - rs_hit=1 if any of these has dest==rs_addr.
  - rs_data is the youngest match: newest queue entry first, output stage last.
  - rs_addr=0 gives rs_hit=0, rs_data=0. No match gives rs_data=0.
  - Same-cycle incoming mem/alu inputs are not searched.
- wb_idle = (count==0) & ~enableLoad.

Test Plan:
- Reset then single push: resetIn 1 for 2 cycles, then alu_valid with dest=5, data=32'hDEADBEEF at edge E -> enableLoad=1, RDadd=5, RD=DEADBEEF exactly in cycle E+1..E+2; enableLoad=0 after; wb_idle=1 by E+2.
- Simultaneous push: mem(dest 3, 0x11) and alu(dest 3, 0x22) in one cycle -> writes appear 3/0x11 then 3/0x22 on consecutive cycles; rs_addr=3 gives rs_data=0x22 while both are pending, then 0x22 while only the second is pending.
- Full boundary: DEPTH=4, hold drain by pushing 2/cycle for 3 cycles -> mem_ready and alu_ready deassert as per free rules when count reaches 3 or 4; all accepted values drain in order with no loss or duplication.
- Register 0: alu dest=0, data=0x55 -> alu_ready=1, no enableLoad pulse, count unchanged, rs_addr=0 gives rs_hit=0.
- Reset mid-drain: 3 entries queued, resetIn asserted for 1 cycle -> enableLoad=0, RDadd=0, RD=0 next cycle; no queued entry is ever written; wb_idle=1.
- Wrap-around: 10 sequential single pushes to dest 1..10 with data=dest*3 -> 10 writes in order, pointers wrap twice, rs_hit=0 for all addresses after drain.

Source files
------------

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_queue
//  Description : In-order writeback queue in front of a 32-entry register
//                file. Accepts memory and ALU results (memory older on a
//                simultaneous accept), drains one write per cycle onto the
//                register file write port, and offers a combinational
//                forwarding lookup over pending and in-flight results.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        CLOCK_50,
  input  logic        resetIn,
  // memory unit result
  input  logic        mem_valid,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  // ALU result
  input  logic        alu_valid,
  input  logic [4:0]  alu_dest,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  // register file write port
  output logic [4:0]  RDadd,
  output logic [31:0] RD,
  output logic        enableLoad,
  // forwarding lookup
  input  logic [4:0]  rs_addr,
  output logic        rs_hit,
  output logic [31:0] rs_data,
  // status
  output logic        wb_idle
);

  // Count needs one extra bit so it can represent a completely full queue.
  localparam int           c_CW    = AW + 1;
  localparam logic [AW:0]  c_DEPTH = c_CW'(DEPTH);
  localparam logic [AW:0]  c_ONE   = c_CW'(1);
  localparam logic [AW:0]  c_TWO   = c_CW'(2);

  // Queue storage
  logic [4:0]       r_dest [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;

  // Pointers and occupancy
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;

  // Output stage (register file write port)
  logic [4:0]       r_out_dest;
  logic [31:0]      r_out_data;
  logic             r_out_en;

  // Handshake / datapath wires
  logic [AW:0]      w_free;
  logic             w_mem_acc;
  logic             w_alu_acc;
  logic             w_mem_push;
  logic             w_alu_push;
  logic             w_pop;
  logic [AW-1:0]    w_alu_slot;
  logic [AW-1:0]    w_wr_ptr_nxt;
  logic [AW:0]      w_count_nxt;

  // Forwarding wires
  logic             w_hit;
  logic [31:0]      w_fwd;
  logic [AW-1:0]    w_idx;

  // Free slots are based on the registered count only; a pop in the same
  // cycle does not make room for a push.
  assign w_free    = c_DEPTH - r_count;

  // The ALU result is younger, so when memory is also presenting it must
  // leave room for the memory result. Deliberately independent of mem_ready.
  assign mem_ready = ~resetIn & (w_free >= c_ONE);
  assign alu_ready = ~resetIn & (mem_valid ? (w_free >= c_TWO) : (w_free >= c_ONE));

  assign w_mem_acc = mem_valid & mem_ready;
  assign w_alu_acc = alu_valid & alu_ready;

  // Writes to r0 are architecturally discarded: accept, but do not enqueue.
  assign w_mem_push = w_mem_acc & (mem_dest != 5'd0);
  assign w_alu_push = w_alu_acc & (alu_dest != 5'd0);

  assign w_pop = (r_count != '0);

  // ALU result lands right behind the memory result if that was enqueued.
  assign w_alu_slot   = r_wr_ptr + AW'(w_mem_push);
  assign w_wr_ptr_nxt = r_wr_ptr + AW'(w_mem_push) + AW'(w_alu_push);
  assign w_count_nxt  = r_count + c_CW'(w_mem_push) + c_CW'(w_alu_push) - c_CW'(w_pop);

  // Pointer, occupancy and output-stage registers
  always_ff @(posedge CLOCK_50) begin
    if (resetIn) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_out_dest <= '0;
      r_out_data <= '0;
      r_out_en   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
      if (w_pop) begin
        r_out_dest <= r_dest[r_rd_ptr];
        r_out_data <= r_data[r_rd_ptr];
        r_out_en   <= 1'b1;
        r_rd_ptr   <= r_rd_ptr + AW'(1);
      end else begin
        r_out_en   <= 1'b0;
      end
    end
  end

  // Entry valid bits: cleared on pop, set on push. Push and pop slots never
  // coincide because a push requires a free slot.
  always_ff @(posedge CLOCK_50) begin
    if (resetIn) begin
      r_valid <= '0;
    end else begin
      if (w_pop)      r_valid[r_rd_ptr]   <= 1'b0;
      if (w_mem_push) r_valid[r_wr_ptr]   <= 1'b1;
      if (w_alu_push) r_valid[w_alu_slot] <= 1'b1;
    end
  end

  // Entry payload storage; contents are qualified by r_valid so no reset.
  always_ff @(posedge CLOCK_50) begin
    if (w_mem_push) begin
      r_dest[r_wr_ptr] <= mem_dest;
      r_data[r_wr_ptr] <= mem_data;
    end
    if (w_alu_push) begin
      r_dest[w_alu_slot] <= alu_dest;
      r_data[w_alu_slot] <= alu_data;
    end
  end

  // Forwarding search: output stage first (oldest), then queue entries from
  // head to tail so that the youngest match overrides older ones.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    w_idx = '0;
    if (r_out_en && (r_out_dest == rs_addr)) begin
      w_hit = 1'b1;
      w_fwd = r_out_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + AW'(i);
      if (r_valid[w_idx] && (r_dest[w_idx] == rs_addr)) begin
        w_hit = 1'b1;
        w_fwd = r_data[w_idx];
      end
    end
    if (rs_addr == 5'd0) begin
      w_hit = 1'b0;
      w_fwd = '0;
    end
  end

  assign rs_hit     = w_hit;
  assign rs_data    = w_fwd;

  assign RDadd      = r_out_dest;
  assign RD         = r_out_data;
  assign enableLoad = r_out_en;

  assign wb_idle    = (r_count == '0) & ~r_out_en;

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_queue
//  Description : Directed self-checking bench for writeback_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_queue;

  logic        CLOCK_50 = 1'b0;
  logic        resetIn;
  logic        mem_valid;
  logic [4:0]  mem_dest;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic [4:0]  RDadd;
  logic [31:0] RD;
  logic        enableLoad;
  logic [4:0]  rs_addr;
  logic        rs_hit;
  logic [31:0] rs_data;
  logic        wb_idle;

  int n_vec = 0;
  int n_err = 0;

  // Writes observed on the register file port, {RDadd, RD}
  logic [36:0] wq[$];

  always #5 CLOCK_50 = ~CLOCK_50;

  writeback_queue #(.DEPTH(4), .AW(2)) dut (
    .CLOCK_50  (CLOCK_50),
    .resetIn   (resetIn),
    .mem_valid (mem_valid),
    .mem_dest  (mem_dest),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .alu_valid (alu_valid),
    .alu_dest  (alu_dest),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .RDadd     (RDadd),
    .RD        (RD),
    .enableLoad(enableLoad),
    .rs_addr   (rs_addr),
    .rs_hit    (rs_hit),
    .rs_data   (rs_data),
    .wb_idle   (wb_idle)
  );

  // Record every register-file write mid-cycle
  always @(negedge CLOCK_50) begin
    if (enableLoad === 1'b1) wq.push_back({RDadd, RD});
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
  endtask

  // Bounded wait for the queue to go idle
  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (wb_idle === 1'b1) begin done = 1'b1; break; end
      step();
    end
    n_vec++;
    if (!done) begin n_err++; $display("FAIL %s_idle_timeout: wb_idle=%0b want 1", tag, wb_idle); end
  endtask

  task automatic test_reset();
    clear_inputs(); rs_addr = '0; resetIn = 1'b1;
    step(); step();
    #1;
    n_vec++; if (enableLoad !== 1'b0) begin n_err++; $display("FAIL rst_en: got %0b want 0", enableLoad); end
    n_vec++; if (RDadd !== 5'd0) begin n_err++; $display("FAIL rst_rdadd: got %0d want 0", RDadd); end
    n_vec++; if (RD !== 32'd0) begin n_err++; $display("FAIL rst_rd: got %h want 0", RD); end
    n_vec++; if (wb_idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %0b want 1", wb_idle); end
    mem_valid = 1'b1; alu_valid = 1'b1; #1;
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rst_mem_ready: got %0b want 0", mem_ready); end
    n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL rst_alu_ready: got %0b want 0", alu_ready); end
    clear_inputs();
    resetIn = 1'b0;
    step();
  endtask

  task automatic test_single_push();
    wq.delete();
    alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hDEADBEEF; rs_addr = 5'd5; #1;
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %0b want 1", alu_ready); end
    step();                       // edge E
    clear_inputs(); #1;
    n_vec++; if (enableLoad !== 1'b0) begin n_err++; $display("FAIL single_en_E: got %0b want 0", enableLoad); end
    n_vec++; if (rs_hit !== 1'b1 || rs_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_fwd_q: got %0b/%h want 1/deadbeef", rs_hit, rs_data); end
    step();                       // edge E+1
    n_vec++; if (enableLoad !== 1'b1 || RDadd !== 5'd5 || RD !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_write: got %0b/%0d/%h want 1/5/deadbeef", enableLoad, RDadd, RD); end
    n_vec++; if (wb_idle !== 1'b0) begin n_err++; $display("FAIL single_busy: got %0b want 0", wb_idle); end
    n_vec++; if (rs_hit !== 1'b1 || rs_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_fwd_out: got %0b/%h want 1/deadbeef", rs_hit, rs_data); end
    step();                       // edge E+2
    n_vec++; if (enableLoad !== 1'b0) begin n_err++; $display("FAIL single_en_off: got %0b want 0", enableLoad); end
    n_vec++; if (wb_idle !== 1'b1) begin n_err++; $display("FAIL single_idle: got %0b want 1", wb_idle); end
    n_vec++; if (RDadd !== 5'd5 || RD !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_hold: got %0d/%h want 5/deadbeef", RDadd, RD); end
    n_vec++; if (rs_hit !== 1'b0) begin n_err++; $display("FAIL single_fwd_gone: got %0b want 0", rs_hit); end
    n_vec++; if (wq.size() != 1) begin n_err++; $display("FAIL single_count: got %0d writes want 1", wq.size()); end
  endtask

  task automatic test_simultaneous();
    mem_valid = 1'b1; mem_dest = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h22; rs_addr = 5'd3; #1;
    n_vec++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_err++; $display("FAIL sim_ready: got %0b/%0b want 1/1", mem_ready, alu_ready); end
    step();
    clear_inputs(); #1;
    n_vec++; if (rs_hit !== 1'b1 || rs_data !== 32'h22) begin n_err++; $display("FAIL sim_fwd_both: got %0b/%h want 1/22", rs_hit, rs_data); end
    step();
    n_vec++; if (enableLoad !== 1'b1 || RDadd !== 5'd3 || RD !== 32'h11) begin n_err++; $display("FAIL sim_write0: got %0b/%0d/%h want 1/3/11", enableLoad, RDadd, RD); end
    n_vec++; if (rs_data !== 32'h22) begin n_err++; $display("FAIL sim_fwd_second: got %h want 22", rs_data); end
    step();
    n_vec++; if (enableLoad !== 1'b1 || RDadd !== 5'd3 || RD !== 32'h22) begin n_err++; $display("FAIL sim_write1: got %0b/%0d/%h want 1/3/22", enableLoad, RDadd, RD); end
    n_vec++; if (rs_hit !== 1'b1 || rs_data !== 32'h22) begin n_err++; $display("FAIL sim_fwd_out: got %0b/%h want 1/22", rs_hit, rs_data); end
    step();
    n_vec++; if (wb_idle !== 1'b1) begin n_err++; $display("FAIL sim_idle: got %0b want 1", wb_idle); end
  endtask

  task automatic test_full_boundary();
    logic [36:0] exp[6];
    exp[0] = {5'd1, 32'hA1}; exp[1] = {5'd2, 32'hA2}; exp[2] = {5'd3, 32'hA3};
    exp[3] = {5'd4, 32'hA4}; exp[4] = {5'd5, 32'hA5}; exp[5] = {5'd6, 32'hA6};
    wq.delete();
    // count 0 -> 2
    mem_valid = 1'b1; mem_dest = 5'd1; mem_data = 32'hA1;
    alu_valid = 1'b1; alu_dest = 5'd2; alu_data = 32'hA2; #1;
    n_vec++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_c0: got %0b/%0b want 1/1", mem_ready, alu_ready); end
    step();
    // count 2 (free 2) -> 3
    mem_dest = 5'd3; mem_data = 32'hA3; alu_dest = 5'd4; alu_data = 32'hA4; #1;
    n_vec++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_c2: got %0b/%0b want 1/1", mem_ready, alu_ready); end
    step();
    // count 3 (free 1): only memory fits when both present
    mem_dest = 5'd5; mem_data = 32'hA5; alu_dest = 5'd6; alu_data = 32'hA6; #1;
    n_vec++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_c3: got %0b/%0b want 1/0", mem_ready, alu_ready); end
    step();
    // count still 3, ALU alone fits
    mem_valid = 1'b0; #1;
    n_vec++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_alu_only: got %0b/%0b want 1/1", mem_ready, alu_ready); end
    step();
    clear_inputs();
    wait_idle("full");
    n_vec++; if (wq.size() != 6) begin n_err++; $display("FAIL full_count: got %0d writes want 6", wq.size()); end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (i >= wq.size() || wq[i] !== exp[i]) begin
        n_err++; $display("FAIL full_order[%0d]: got %h want %h", i, (i < wq.size()) ? wq[i] : 37'h0, exp[i]);
      end
    end
  endtask

  task automatic test_reg0();
    wq.delete();
    alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'h55; rs_addr = 5'd0; #1;
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL r0_ready: got %0b want 1", alu_ready); end
    n_vec++; if (rs_hit !== 1'b0 || rs_data !== 32'd0) begin n_err++; $display("FAIL r0_fwd: got %0b/%h want 0/0", rs_hit, rs_data); end
    step();
    clear_inputs(); #1;
    n_vec++; if (wb_idle !== 1'b1) begin n_err++; $display("FAIL r0_idle: got %0b want 1", wb_idle); end
    step(); step();
    n_vec++; if (wq.size() != 0) begin n_err++; $display("FAIL r0_nowrite: got %0d writes want 0", wq.size()); end
  endtask

  task automatic test_reset_mid_drain();
    mem_valid = 1'b1; mem_dest = 5'd7; mem_data = 32'h71;
    alu_valid = 1'b1; alu_dest = 5'd8; alu_data = 32'h72;
    step();
    mem_dest = 5'd9; mem_data = 32'h73; alu_dest = 5'd10; alu_data = 32'h74;
    step();                       // 3 queued, 7/71 on the write port
    clear_inputs();
    resetIn = 1'b1; mem_valid = 1'b1; alu_valid = 1'b1; mem_dest = 5'd11; alu_dest = 5'd12; #1;
    n_vec++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0) begin n_err++; $display("FAIL rmd_ready: got %0b/%0b want 0/0", mem_ready, alu_ready); end
    step();
    clear_inputs(); resetIn = 1'b0; wq.delete(); rs_addr = 5'd8; #1;
    n_vec++; if (enableLoad !== 1'b0 || RDadd !== 5'd0 || RD !== 32'd0) begin n_err++; $display("FAIL rmd_out: got %0b/%0d/%h want 0/0/0", enableLoad, RDadd, RD); end
    n_vec++; if (wb_idle !== 1'b1) begin n_err++; $display("FAIL rmd_idle: got %0b want 1", wb_idle); end
    n_vec++; if (rs_hit !== 1'b0) begin n_err++; $display("FAIL rmd_fwd: got %0b want 0", rs_hit); end
    repeat (5) step();
    n_vec++; if (wq.size() != 0) begin n_err++; $display("FAIL rmd_nowrite: got %0d writes want 0", wq.size()); end
  endtask

  task automatic test_wrap();
    logic [36:0] e;
    wq.delete();
    for (int d = 1; d <= 10; d++) begin
      alu_valid = 1'b1; alu_dest = 5'(d); alu_data = 32'(d * 3); #1;
      n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL wrap_ready[%0d]: got %0b want 1", d, alu_ready); end
      step();
    end
    clear_inputs();
    wait_idle("wrap");
    n_vec++; if (wq.size() != 10) begin n_err++; $display("FAIL wrap_count: got %0d writes want 10", wq.size()); end
    for (int d = 1; d <= 10; d++) begin
      e = {5'(d), 32'(d * 3)};
      n_vec++;
      if (d > wq.size() || wq[d-1] !== e) begin
        n_err++; $display("FAIL wrap_order[%0d]: got %h want %h", d, (d <= wq.size()) ? wq[d-1] : 37'h0, e);
      end
    end
    for (int a = 1; a <= 10; a++) begin
      rs_addr = 5'(a); #1;
      n_vec++; if (rs_hit !== 1'b0) begin n_err++; $display("FAIL wrap_fwd[%0d]: got %0b want 0", a, rs_hit); end
    end
  endtask

  initial begin
    clear_inputs();
    rs_addr = '0;
    resetIn = 1'b1;
    test_reset();
    test_single_push();
    test_simultaneous();
    test_full_boundary();
    test_reg0();
    test_reset_mid_drain();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
